cpu_control_sequencer: RTL and testbench
========================================

Name: cpu_control_sequencer

Overview:
- Microcoded control unit for the 8-bit bus CPU, acting as the initiator that drives the program counter (ce/co/j) and every other bus participant.
- Steps each instruction through fetch and execute T-states from the IR opcode and flags, emitting one control word per clock.
- Sits between the instruction register/flags register and all datapath enables.

Parameters:
OPCODE_W, 4, opcode width from IR high nibble
STEP_W, 3, T-state counter width
MAX_STEP, 4, highest T-state index; forced wrap point

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  1 = sequence; 0 = freeze step, outputs forced 0
opcode  in  OPCODE_W  IR[7:4], valid from T2
carry_flag  in  1  registered carry flag
zero_flag  in  1  registered zero flag
hlt  out  1  halt indicator / clock-gate request
mi  out  1  MAR load from bus
ri  out  1  RAM write from bus
ro  out  1  RAM drives bus
io  out  1  IR low nibble drives bus
ii  out  1  IR load from bus
ai  out  1  A register load
ao  out  1  A register drives bus
eo  out  1  ALU drives bus
su  out  1  ALU subtract
bi  out  1  B register load
oi  out  1  output register load
ce  out  1  PC count enable
co  out  1  PC drives bus
j  out  1  PC load (jump)
fi  out  1  flags register load
step  out  STEP_W  current T-state (debug)
halted  out  1  sticky halt state

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. On reset, step=0 and halted=0. While rst=1, all control outputs are 0.
- Control outputs are combinational from (step, opcode, flags, halted, run). The datapath captures on the same rising edge on which step advances.
- Fetch, all opcodes:
  - T0: co, mi.
  - T1: ro, ii, ce. IR loads at the end of T1, so opcode is valid in T2.
- Execute, by opcode; "last" marks the final step of each instruction:
  - 0000 NOP: T2 empty, last.
  - 0001 LDA: T2 io,mi; T3 ro,ai, last.
  - 0010 ADD: T2 io,mi; T3 ro,bi; T4 eo,ai,fi, last.
  - 0011 SUB: as ADD, with T4 also asserting su.
  - 0100 STA: T2 io,mi; T3 ao,ri, last.
  - 0101 LDI: T2 io,ai, last.
  - 0110 JMP: T2 io,j, last.
  - 0111 JC: T2 io,j if carry_flag=1, else empty; last either way.
  - 1000 JZ: as JC, using zero_flag.
  - 1110 OUT: T2 ao,oi, last.
  - 1111 HLT: T2 hlt, last; sets halted on that edge.
  - Undefined opcodes behave as NOP.
- Step update on rising edge when run=1 and halted=0:
  - If last, or step==MAX_STEP, step goes to 0.
  - Otherwise step increments.
  - Step never exceeds MAX_STEP.
- Instruction lengths in cycles: NOP/LDI/JMP/JC/JZ/OUT/HLT 3; LDA/STA 4; ADD/SUB 5.
- run=0: step holds and all control outputs are 0. Resuming continues from the held step with no lost or duplicated T-state.
- Halted:
  - step holds, hlt=1, all other outputs 0, run ignored.
  - Only rst clears it.
- Flags are sampled combinationally during T2 only. Flag changes in other steps have no effect.
- Reset mid-instruction: the sequencer abandons the instruction. After release, the first active cycle is T0 (co, mi).
- At most one bus driver (ro, io, ao, eo, co) is active in any word.

Decomposition:
- Package cpu_ctrl_pkg:
  - opcode localparams (OP_NOP…OP_HLT)
  - T-state constants T0..T4
  - control-word bit indices
  - control-word width constant
- Sub-module cpu_microcode_rom: purely combinational. Inputs opcode, step, carry_flag, zero_flag; outputs control word and last.
- The top holds the step and halted registers, plus run/halt/reset gating.

Test Plan:
- Reset then run=1, opcode=0001 (LDA):
  - steps 0,1,2,3,0.
  - words: {co,mi}, {ro,ii,ce}, {io,mi}, {ro,ai}.
  - fi never high.
- opcode=0011 (SUB): 5 cycles; T4 word = {eo,ai,su,fi}; next cycle step=0.
- opcode=0111 (JC):
  - carry_flag=1: T2 = {io,j}.
  - carry_flag=0: T2 word = 0, step returns to 0 after 3 cycles.
  - carry toggled during T3 of the preceding ADD has no effect.
- opcode=1111 (HLT) at T2:
  - halted=1 and hlt=1 from the next cycle; step frozen at 2.
  - 10 further clocks with run toggling: no change.
  - rst pulse → step=0, halted=0.
- run dropped at T3 of ADD for 4 cycles: outputs all 0, step=3 held; on resume T3 {ro,bi} then T4 {eo,ai,fi}.
- rst asserted asynchronously mid-T3 of STA: outputs 0 immediately; after release T0 {co,mi}. Sweep all 16 opcodes through T2 and check one-hot bus drivers.

Source files
------------

// File: rtl/cpu_control_sequencer_pkg.sv
// Shared constants for the bus CPU control sequencer: widths, opcodes,
// T-state numbers and the bit layout of the control word.
package cpu_ctrl_pkg;

    localparam int OPCODE_W = 4;
    localparam int STEP_W   = 3;
    localparam int MAX_STEP = 4;

    localparam logic [OPCODE_W-1:0] OP_NOP = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_LDI = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_JC  = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

    localparam logic [STEP_W-1:0] T0 = 3'd0;
    localparam logic [STEP_W-1:0] T1 = 3'd1;
    localparam logic [STEP_W-1:0] T2 = 3'd2;
    localparam logic [STEP_W-1:0] T3 = 3'd3;
    localparam logic [STEP_W-1:0] T4 = 3'd4;

    localparam int CW_FI  = 0;
    localparam int CW_J   = 1;
    localparam int CW_CO  = 2;
    localparam int CW_CE  = 3;
    localparam int CW_OI  = 4;
    localparam int CW_BI  = 5;
    localparam int CW_SU  = 6;
    localparam int CW_EO  = 7;
    localparam int CW_AO  = 8;
    localparam int CW_AI  = 9;
    localparam int CW_II  = 10;
    localparam int CW_IO  = 11;
    localparam int CW_RO  = 12;
    localparam int CW_RI  = 13;
    localparam int CW_MI  = 14;
    localparam int CW_HLT = 15;
    localparam int CW_W   = 16;

    typedef logic [CW_W-1:0] ctrl_word_t;

    typedef enum logic {
        SEQ_RUN,
        SEQ_HALT
    } seq_state_t;

endpackage

// File: rtl/cpu_control_sequencer_if.sv
// Bundle of sequencer inputs (run, IR opcode, flags) and the control word
// fanned out to every datapath participant.
interface cpu_control_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic                run;
    logic [OPCODE_W-1:0] opcode;
    logic                carry_flag;
    logic                zero_flag;
    logic                hlt;
    logic                mi;
    logic                ri;
    logic                ro;
    logic                io;
    logic                ii;
    logic                ai;
    logic                ao;
    logic                eo;
    logic                su;
    logic                bi;
    logic                oi;
    logic                ce;
    logic                co;
    logic                j;
    logic                fi;
    logic [STEP_W-1:0]   step;
    logic                halted;

    modport master (
        input  run, opcode, carry_flag, zero_flag,
        output hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi,
        output step, halted
    );

    modport slave (
        output run, opcode, carry_flag, zero_flag,
        input  hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi,
        input  step, halted
    );

endinterface

// File: rtl/cpu_control_sequencer_rom.sv
// Combinational microcode: maps (opcode, T-state, flags) to a control word
// and marks the final T-state of each instruction.
module cpu_microcode_rom
    import cpu_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic [STEP_W-1:0]   i_step,
    input  logic                i_carry_flag,
    input  logic                i_zero_flag,
    output ctrl_word_t          o_cw,
    output logic                o_last
);

    // Steps beyond an instruction's end report last so the counter can never run away.
    always_comb begin
        o_cw   = '0;
        o_last = 1'b0;
        case (i_step)
            T0: begin
                o_cw[CW_CO] = 1'b1;
                o_cw[CW_MI] = 1'b1;
            end
            T1: begin
                o_cw[CW_RO] = 1'b1;
                o_cw[CW_II] = 1'b1;
                o_cw[CW_CE] = 1'b1;
            end
            T2: begin
                o_last = 1'b1;
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        o_cw[CW_IO] = 1'b1;
                        o_cw[CW_MI] = 1'b1;
                        o_last      = 1'b0;
                    end
                    OP_LDI: begin
                        o_cw[CW_IO] = 1'b1;
                        o_cw[CW_AI] = 1'b1;
                    end
                    OP_JMP: begin
                        o_cw[CW_IO] = 1'b1;
                        o_cw[CW_J]  = 1'b1;
                    end
                    OP_JC: begin
                        o_cw[CW_IO] = i_carry_flag;
                        o_cw[CW_J]  = i_carry_flag;
                    end
                    OP_JZ: begin
                        o_cw[CW_IO] = i_zero_flag;
                        o_cw[CW_J]  = i_zero_flag;
                    end
                    OP_OUT: begin
                        o_cw[CW_AO] = 1'b1;
                        o_cw[CW_OI] = 1'b1;
                    end
                    OP_HLT: o_cw[CW_HLT] = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                o_last = 1'b1;
                case (i_opcode)
                    OP_LDA: begin
                        o_cw[CW_RO] = 1'b1;
                        o_cw[CW_AI] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        o_cw[CW_RO] = 1'b1;
                        o_cw[CW_BI] = 1'b1;
                        o_last      = 1'b0;
                    end
                    OP_STA: begin
                        o_cw[CW_AO] = 1'b1;
                        o_cw[CW_RI] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                o_last = 1'b1;
                if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
                    o_cw[CW_EO] = 1'b1;
                    o_cw[CW_AI] = 1'b1;
                    o_cw[CW_FI] = 1'b1;
                    o_cw[CW_SU] = (i_opcode == OP_SUB);
                end
            end
            default: o_last = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Control sequencer top: owns the T-state counter and sticky halt state, and
// gates the microcode word with reset, run and halt.
module cpu_control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    cpu_control_sequencer_if.master  bus
);

    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] w_stepNext;
    seq_state_t        r_state;
    seq_state_t        w_stateNext;
    ctrl_word_t        w_romCw;
    ctrl_word_t        w_cw;
    logic              w_last;

    cpu_microcode_rom u_rom (
        .i_opcode     (bus.opcode),
        .i_step       (r_step),
        .i_carry_flag (bus.carry_flag),
        .i_zero_flag  (bus.zero_flag),
        .o_cw         (w_romCw),
        .o_last       (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step  <= T0;
            r_state <= SEQ_RUN;
        end else begin
            r_step  <= w_stepNext;
            r_state <= w_stateNext;
        end
    end

    // A HLT word freezes the step where it is; only reset leaves SEQ_HALT.
    always_comb begin
        w_stepNext  = r_step;
        w_stateNext = r_state;
        w_cw        = '0;
        if (r_state == SEQ_HALT) begin
            w_cw[CW_HLT] = 1'b1;
        end else if (bus.run) begin
            w_cw = w_romCw;
            if (w_romCw[CW_HLT]) begin
                w_stateNext = SEQ_HALT;
            end else if (w_last || r_step == STEP_W'(MAX_STEP)) begin
                w_stepNext = T0;
            end else begin
                w_stepNext = r_step + 1'b1;
            end
        end
        if (rst) begin
            w_cw = '0;
        end
    end

    assign bus.hlt    = w_cw[CW_HLT];
    assign bus.mi     = w_cw[CW_MI];
    assign bus.ri     = w_cw[CW_RI];
    assign bus.ro     = w_cw[CW_RO];
    assign bus.io     = w_cw[CW_IO];
    assign bus.ii     = w_cw[CW_II];
    assign bus.ai     = w_cw[CW_AI];
    assign bus.ao     = w_cw[CW_AO];
    assign bus.eo     = w_cw[CW_EO];
    assign bus.su     = w_cw[CW_SU];
    assign bus.bi     = w_cw[CW_BI];
    assign bus.oi     = w_cw[CW_OI];
    assign bus.ce     = w_cw[CW_CE];
    assign bus.co     = w_cw[CW_CO];
    assign bus.j      = w_cw[CW_J];
    assign bus.fi     = w_cw[CW_FI];
    assign bus.step   = r_step;
    assign bus.halted = (r_state == SEQ_HALT);

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Scoreboard bench for cpu_control_sequencer: directed scenarios followed by
// random instruction streams, checked against an instruction-level model.
module tb_cpu_control_sequencer;

    localparam logic [15:0] W_HLT = 16'h8000;
    localparam logic [15:0] W_MI  = 16'h4000;
    localparam logic [15:0] W_RI  = 16'h2000;
    localparam logic [15:0] W_RO  = 16'h1000;
    localparam logic [15:0] W_IO  = 16'h0800;
    localparam logic [15:0] W_II  = 16'h0400;
    localparam logic [15:0] W_AI  = 16'h0200;
    localparam logic [15:0] W_AO  = 16'h0100;
    localparam logic [15:0] W_EO  = 16'h0080;
    localparam logic [15:0] W_SU  = 16'h0040;
    localparam logic [15:0] W_BI  = 16'h0020;
    localparam logic [15:0] W_OI  = 16'h0010;
    localparam logic [15:0] W_CE  = 16'h0008;
    localparam logic [15:0] W_CO  = 16'h0004;
    localparam logic [15:0] W_J   = 16'h0002;
    localparam logic [15:0] W_FI  = 16'h0001;

    typedef struct {
        logic [15:0] word;
        int          step;
        logic        halted;
    } exp_t;

    logic clk;
    logic rst;
    cpu_control_sequencer_if ifc ();

    cpu_control_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sbQ[$];
    int   checkCount = 0;
    int   failCount  = 0;
    int   mStep      = 0;
    bit   mHalted    = 1'b0;

    function automatic int instrLen(input logic [3:0] op);
        case (op)
            4'b0001, 4'b0100: return 4;
            4'b0010, 4'b0011: return 5;
            default:          return 3;
        endcase
    endfunction

    // The word an instruction issues at T-state t, straight from its listing.
    function automatic logic [15:0] refWord(input logic [3:0] op, input int t,
                                            input bit c, input bit z);
        if (t == 0) return W_CO | W_MI;
        if (t == 1) return W_RO | W_II | W_CE;
        case (op)
            4'b0001: return (t == 2) ? (W_IO | W_MI) : (W_RO | W_AI);
            4'b0010: return (t == 2) ? (W_IO | W_MI) : (t == 3) ? (W_RO | W_BI) : (W_EO | W_AI | W_FI);
            4'b0011: return (t == 2) ? (W_IO | W_MI) : (t == 3) ? (W_RO | W_BI) : (W_EO | W_AI | W_FI | W_SU);
            4'b0100: return (t == 2) ? (W_IO | W_MI) : (W_AO | W_RI);
            4'b0101: return W_IO | W_AI;
            4'b0110: return W_IO | W_J;
            4'b0111: return c ? (W_IO | W_J) : 16'h0000;
            4'b1000: return z ? (W_IO | W_J) : 16'h0000;
            4'b1110: return W_AO | W_OI;
            4'b1111: return W_HLT;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus: predict this cycle's response, queue it, advance the model.
    task automatic applyStimulus(input bit runV, input logic [3:0] op, input bit c,
                                 input bit z, input bit rstV);
        exp_t        e;
        logic [15:0] w;
        ifc.run        = runV;
        ifc.opcode     = op;
        ifc.carry_flag = c;
        ifc.zero_flag  = z;
        rst            = rstV;
        if (rstV) begin
            mStep   = 0;
            mHalted = 1'b0;
            w       = 16'h0000;
        end else if (mHalted) begin
            w = W_HLT;
        end else if (!runV) begin
            w = 16'h0000;
        end else begin
            w = refWord(op, mStep, c, z);
        end
        e.word   = w;
        e.step   = mStep;
        e.halted = mHalted;
        sbQ.push_back(e);
        if (!rstV && !mHalted && runV) begin
            if (w == W_HLT) mHalted = 1'b1;
            else mStep = (mStep + 1 >= instrLen(op)) ? 0 : mStep + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runInstr(input logic [3:0] op, input bit c, input bit z);
        for (int k = 0; k < instrLen(op); k++) applyStimulus(1'b1, op, c, z, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        int          drivers;
        if (sbQ.size() != 0) begin
            e   = sbQ.pop_front();
            act = {ifc.hlt, ifc.mi, ifc.ri, ifc.ro, ifc.io, ifc.ii, ifc.ai, ifc.ao,
                   ifc.eo, ifc.su, ifc.bi, ifc.oi, ifc.ce, ifc.co, ifc.j, ifc.fi};
            drivers = int'(ifc.ro) + int'(ifc.io) + int'(ifc.ao) + int'(ifc.eo) + int'(ifc.co);
            checkOutput("controlWord", {16'h0, act}, {16'h0, e.word});
            checkOutput("step", {29'h0, ifc.step}, e.step);
            checkOutput("halted", {31'h0, ifc.halted}, {31'h0, e.halted});
            checkOutput("busDriversOneHot", (drivers <= 1) ? 1 : 0, 1);
        end
    end

    initial begin
        logic [3:0] curOp;
        rst            = 1'b1;
        ifc.run        = 1'b0;
        ifc.opcode     = 4'h0;
        ifc.carry_flag = 1'b0;
        ifc.zero_flag  = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b1);

        runInstr(4'b0001, 1'b0, 1'b0);
        runInstr(4'b0011, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 4'b0010, k[0], 1'b0, 1'b0);
        runInstr(4'b0111, 1'b1, 1'b0);
        runInstr(4'b0111, 1'b0, 1'b1);
        runInstr(4'b1000, 1'b0, 1'b1);

        // ADD stalled at T3 for four cycles, then resumed.
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);

        // STA abandoned by an asynchronous reset during T3.
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b1);
        runInstr(4'b0001, 1'b0, 1'b0);

        for (int op = 0; op < 15; op++) begin
            curOp = 4'(op);
            runInstr(curOp, op[0], op[1]);
        end

        runInstr(4'b1111, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) applyStimulus(k[0], 4'($urandom_range(0, 15)), 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
        runInstr(4'b1110, 1'b0, 1'b0);

        curOp = 4'h0;
        for (int k = 0; k < 600; k++) begin
            if (mStep == 0 && !mHalted) begin
                curOp = 4'($urandom_range(0, 15));
                if (curOp == 4'b1111 && $urandom_range(0, 3) != 0) curOp = 4'b0010;
            end
            applyStimulus(($urandom_range(0, 7) != 0), curOp, 1'($urandom), 1'($urandom),
                          (mHalted && $urandom_range(0, 5) == 0) || $urandom_range(0, 99) == 0);
        end
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        checkOutput("scoreboardDrained", sbQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
